// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and writeback types for the register-file writeback arbiter
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    typedef enum logic {WB_SRC_ALU = 1'b0, WB_SRC_LSU = 1'b1} wb_src_t;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with set-over-clear priority and hazard lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_set_rd,
    input  logic                clr,
    input  logic [AW-1:0]       clr_rd,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                hazard
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_x0;

    assign w_set = {{(NUM_REGS-1){1'b0}}, sb_set} << sb_set_rd;
    assign w_clr = {{(NUM_REGS-1){1'b0}}, clr} << clr_rd;
    assign w_x0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

    // Clear on commit, set on issue (set wins), register 0 can never be pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~w_x0;
    end

    assign busy_mask = r_busy;
    assign hazard    = r_busy[rs1_addr] || r_busy[rs2_addr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU writeback arbiter with registered RF write port and scoreboard
// Optional: define REGFILE_WB_STATS_EN to add the saturating conflict_count output.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN     = regfile_pkg::XLEN,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [AW-1:0]       lsu_rd,
    input  logic [XLEN-1:0]     lsu_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_set_rd,
    input  logic [AW-1:0]       rs1_addr,
    input  logic [AW-1:0]       rs2_addr,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                rf_w_enable,
    output logic [AW-1:0]       rf_w_address,
    output logic [XLEN-1:0]     rf_w_data
`ifdef REGFILE_WB_STATS_EN
    ,
    output logic [31:0]         conflict_count
`endif
);
    wb_src_t         r_ptr;
    logic            r_w_en;
    logic [AW-1:0]   r_w_addr;
    logic [XLEN-1:0] r_w_data;
    logic            w_conflict;
    logic            w_grant;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;

    assign w_conflict = alu_valid && lsu_valid;
    assign alu_ready  = alu_valid && (!lsu_valid || r_ptr == WB_SRC_ALU);
    assign lsu_ready  = lsu_valid && (!alu_valid || r_ptr == WB_SRC_LSU);
    assign w_grant    = alu_ready || lsu_ready;
    assign w_rd       = alu_ready ? alu_rd : lsu_rd;
    assign w_data     = alu_ready ? alu_data : lsu_data;

    // Round-robin pointer names the conflict winner and flips only on a two-way conflict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= WB_SRC_ALU;
        else if (w_conflict)
            r_ptr <= (r_ptr == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    end

    // Register the granted write; x0 writes are accepted but never reach the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_grant && (w_rd != '0);
            if (w_grant) begin
                r_w_addr <= w_rd;
                r_w_data <= w_data;
            end
        end
    end

    assign rf_w_enable  = r_w_en;
    assign rf_w_address = r_w_addr;
    assign rf_w_data    = r_w_data;

    regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sb_set    (sb_set),
        .sb_set_rd (sb_set_rd),
        .clr       (r_w_en),
        .clr_rd    (r_w_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .busy_mask (busy_mask),
        .hazard    (hazard)
    );

`ifdef REGFILE_WB_STATS_EN
    logic [31:0] r_conf;

    // Count cycles with both sources requesting, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_conf <= '0;
        else if (w_conflict && r_conf != '1)
            r_conf <= r_conf + 32'd1;
    end

    assign conflict_count = r_conf;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus checked against a behavioural writeback/scoreboard model
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, sb_set_rd, rs1_addr, rs2_addr, rf_w_address;
    logic [31:0] alu_data, lsu_data, rf_w_data, busy_mask;
    logic        sb_set, hazard, rf_w_enable;
`ifdef REGFILE_WB_STATS_EN
    logic [31:0] conflict_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_busy [32];
    bit          m_fav_alu;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    longint      m_conf;
    bit          acc_alu, acc_lsu;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .sb_set       (sb_set),
        .sb_set_rd    (sb_set_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard       (hazard),
        .busy_mask    (busy_mask),
        .rf_w_enable  (rf_w_enable),
        .rf_w_address (rf_w_address),
        .rf_w_data    (rf_w_data)
`ifdef REGFILE_WB_STATS_EN
        ,
        .conflict_count (conflict_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_fav_alu = 1'b1;
        m_wen     = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_conf    = 0;
        acc_alu   = 1'b0;
        acc_lsu   = 1'b0;
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        sb_set = 0; sb_set_rd = 0; rs1_addr = 0; rs2_addr = 0;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check registered outputs after it
    task automatic cycle();
        bit g_alu, g_lsu;
        #1;
        if (alu_valid && lsu_valid) begin
            g_alu = m_fav_alu;
            g_lsu = !m_fav_alu;
        end else begin
            g_alu = alu_valid;
            g_lsu = lsu_valid;
        end
        check("alu_ready", alu_ready, g_alu);
        check("lsu_ready", lsu_ready, g_lsu);
        check("hazard", hazard, m_busy[rs1_addr] || m_busy[rs2_addr]);
        @(posedge clk);
        for (int r = 1; r < 32; r++) begin
            if (sb_set && sb_set_rd == r) m_busy[r] = 1'b1;
            else if (m_wen && m_waddr == r) m_busy[r] = 1'b0;
        end
        if (g_alu || g_lsu) begin
            m_waddr = g_alu ? alu_rd : lsu_rd;
            m_wdata = g_alu ? alu_data : lsu_data;
            m_wen   = (m_waddr != 0);
        end else begin
            m_wen = 1'b0;
        end
        if (alu_valid && lsu_valid) begin
            m_fav_alu = !m_fav_alu;
            if (m_conf < 64'hFFFF_FFFF) m_conf++;
        end
        acc_alu = g_alu;
        acc_lsu = g_lsu;
        #1;
        check("rf_w_enable", rf_w_enable, m_wen);
        if (m_wen) begin
            check("rf_w_address", rf_w_address, m_waddr);
            check("rf_w_data", rf_w_data, m_wdata);
        end
        check("busy_mask", busy_mask, model_mask());
`ifdef REGFILE_WB_STATS_EN
        check("conflict_count", conflict_count, m_conf);
`endif
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst_wen", rf_w_enable, 1'b0);
        check("rst_addr", rf_w_address, 5'd0);
        check("rst_data", rf_w_data, 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        rst_n = 1'b1;

        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cycle();
        check("t1_wen", rf_w_enable, 1'b1);
        check("t1_addr", rf_w_address, 5'd5);
        check("t1_data", rf_w_data, 32'hDEADBEEF);
        idle_inputs();
        cycle();
        check("t1_wen_drop", rf_w_enable, 1'b0);

        alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A1_0001;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 32'hB2B2_0002;
        cycle();
        check("t2_grant1_alu", rf_w_address, 5'd1);
        alu_data = 32'hA1A1_0003;
        cycle();
        check("t2_grant2_lsu", rf_w_data, 32'hB2B2_0002);
        lsu_data = 32'hB2B2_0004;
        cycle();
        check("t2_grant3_alu", rf_w_data, 32'hA1A1_0003);
        alu_valid = 0;
        cycle();
        idle_inputs();
        cycle();

        sb_set = 1; sb_set_rd = 7;
        cycle();
        sb_set = 0; rs1_addr = 7;
        cycle();
        check("t3_hazard_set", hazard, 1'b1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_7777;
        cycle();
        lsu_valid = 0;
        check("t3_hazard_commit", hazard, 1'b1);
        cycle();
        check("t3_hazard_clear", hazard, 1'b0);
        check("t3_busy7", busy_mask[7], 1'b0);
        cycle();

        sb_set = 1; sb_set_rd = 9;
        cycle();
        sb_set = 0; alu_valid = 1; alu_rd = 9; alu_data = 32'h9999;
        cycle();
        alu_valid = 0; sb_set = 1; sb_set_rd = 9;
        cycle();
        sb_set = 0;
        check("t4_set_wins", busy_mask[9], 1'b1);
        alu_valid = 1; alu_rd = 9; alu_data = 32'h9A9A;
        cycle();
        idle_inputs();
        cycle();
        cycle();

        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; sb_set = 1; sb_set_rd = 0; rs1_addr = 0;
        cycle();
        check("t5_x0_wen", rf_w_enable, 1'b0);
        idle_inputs();
        cycle();
        check("t5_x0_busy", busy_mask, 32'd0);

        sb_set = 1; sb_set_rd = 3;
        cycle();
        sb_set_rd = 4;
        cycle();
        sb_set = 0; alu_valid = 1; alu_rd = 3; alu_data = 32'h3333;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h4444;
        cycle();
        rst_n = 1'b0;
        #1;
        check("t6_rst_wen", rf_w_enable, 1'b0);
        check("t6_rst_busy", busy_mask, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        check("t6_first_conflict_alu", rf_w_address, 5'd3);
        idle_inputs();
        cycle();

        for (int k = 0; k < 400; k++) begin
            if (!(alu_valid && !acc_alu)) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!(lsu_valid && !acc_lsu)) begin
                lsu_valid = 1'($urandom_range(0, 1));
                lsu_rd    = 5'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            sb_set    = ($urandom_range(0, 2) == 0);
            sb_set_rd = 5'($urandom_range(0, 31));
            rs1_addr  = 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
